// File: rtl/computer_system_irq_aggregator.sv
// Interrupt aggregator: collects up to 16 peripheral interrupt sources,
// latches them (edge mode) or follows them (level mode), masks them with a
// per-source enable, and exposes raw/pending/active/highest-priority status
// over a 16-bit Avalon-MM slave. A single registered irq_out goes to the CPU.
module computer_system_irq_aggregator #(
    parameter int          NUM_IRQ    = 8,
    parameter logic [15:0] EDGE_RESET = 16'hFFFF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    output logic               irq_out
);

    localparam logic [2:0] ADDR_RAW        = 3'd0;
    localparam logic [2:0] ADDR_PENDING    = 3'd1;
    localparam logic [2:0] ADDR_ENABLE     = 3'd2;
    localparam logic [2:0] ADDR_EDGE_SEL   = 3'd3;
    localparam logic [2:0] ADDR_ACTIVE     = 3'd4;
    localparam logic [2:0] ADDR_HIGHEST    = 3'd5;
    localparam logic [2:0] ADDR_ENABLE_SET = 3'd6;
    localparam logic [2:0] ADDR_ENABLE_CLR = 3'd7;

    // Source sampling and edge detection
    logic [NUM_IRQ-1:0] in_q;
    logic [NUM_IRQ-1:0] in_d;
    logic [NUM_IRQ-1:0] rise;

    // Architectural registers
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] enable_q, enable_d;
    logic [NUM_IRQ-1:0] edge_sel_q, edge_sel_d;
    logic [15:0]        readdata_q, readdata_d;
    logic               irq_out_q;

    // Derived status
    logic [NUM_IRQ-1:0] active;
    logic [NUM_IRQ-1:0] mode_chg;
    logic [15:0]        highest;
    logic [3:0]         high_idx;

    // Bus decode; only the implemented source bits of writedata matter
    logic               wr_en;
    logic               w1c_en;
    logic [NUM_IRQ-1:0] wdata;
    logic               unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign w1c_en       = wr_en && (address == ADDR_PENDING);
    assign wdata        = writedata[NUM_IRQ-1:0];
    assign unused_wdata = ^writedata;

    assign rise   = in_q & ~in_d;
    assign active = pending_q & enable_q;

    // Next ENABLE: direct write, or bitwise set/clear through the alias ports
    always_comb begin
        enable_d = enable_q;
        if (wr_en) begin
            case (address)
                ADDR_ENABLE:     enable_d = wdata;
                ADDR_ENABLE_SET: enable_d = enable_q | wdata;
                ADDR_ENABLE_CLR: enable_d = enable_q & ~wdata;
                default:         enable_d = enable_q;
            endcase
        end
    end

    assign edge_sel_d = (wr_en && (address == ADDR_EDGE_SEL)) ? wdata : edge_sel_q;
    assign mode_chg   = edge_sel_q ^ edge_sel_d;

    // Per-source pending: a mode switch discards stale state; in edge mode a
    // new rise beats a simultaneous W1C so no interrupt is ever lost.
    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_pending
            assign pending_d[gi] = mode_chg[gi]   ? 1'b0 :
                                   edge_sel_q[gi] ? (rise[gi] |
                                                     (pending_q[gi] & ~(w1c_en & wdata[gi]))) :
                                                    in_q[gi];
        end
    endgenerate

    // Priority encoder: lowest-numbered active source wins
    always_comb begin
        high_idx = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) high_idx = 4'(i);
        end
        highest = (|active) ? {1'b1, 11'b0, high_idx} : 16'h0000;
    end

    // Read mux uses pre-write register values; unimplemented bits read 0
    always_comb begin
        readdata_d = 16'h0000;
        case (address)
            ADDR_RAW:      readdata_d = 16'(in_q);
            ADDR_PENDING:  readdata_d = 16'(pending_q);
            ADDR_ENABLE:   readdata_d = 16'(enable_q);
            ADDR_EDGE_SEL: readdata_d = 16'(edge_sel_q);
            ADDR_ACTIVE:   readdata_d = 16'(active);
            ADDR_HIGHEST:  readdata_d = highest;
            default:       readdata_d = 16'h0000;
        endcase
    end

    // State update; all state is cleared asynchronously so a held-off CPU
    // sees a quiet interrupt line the instant reset asserts
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_q       <= '0;
            in_d       <= '0;
            pending_q  <= '0;
            enable_q   <= '0;
            edge_sel_q <= EDGE_RESET[NUM_IRQ-1:0];
            readdata_q <= 16'h0000;
            irq_out_q  <= 1'b0;
        end else begin
            in_q       <= irq_in;
            in_d       <= in_q;
            pending_q  <= pending_d;
            enable_q   <= enable_d;
            edge_sel_q <= edge_sel_d;
            readdata_q <= readdata_d;
            irq_out_q  <= |active;
        end
    end

    assign readdata = readdata_q;
    assign irq_out  = irq_out_q;

endmodule
